ar_r_read_arbiter: RTL and testbench
====================================

// Module: ar_r_read_arbiter
// PURPOSE
//  Shares the AXI read channels (AR/R) between the inst and data sram-like ports inside sram2axi_bridge.
//  Picks one read per cycle, tags it with a source ID, and routes R beats back by rid.
//  Blocks a data read that hits a write still pending in the AW/W/B path (RAW hazard).
//  Reads from both sources may be in flight together: at most one read per source outstanding.
// PARAMETERS
//  ADDR_W   32  address width
//  DATA_W   32  data width
//  ID_W     4   AXI id width
//  INST_ID  0   arid used for inst reads
//  DATA_ID  1   arid used for data reads
// PORTS
//  clk               in   1       clock, all logic on rising edge
//  resetn            in   1       asynchronous, active-low reset
//  inst_sram_req     in   1       inst read request
//  inst_sram_size    in   2       log2 bytes
//  inst_sram_addr    in   ADDR_W  byte address
//  inst_sram_addr_ok out  1       request accepted this cycle
//  inst_sram_data_ok out  1       one-cycle pulse, rdata valid
//  inst_sram_rdata   out  DATA_W  read data
//  data_sram_req     in   1       data request (reads only; wr=1 ignored here)
//  data_sram_wr      in   1       1=write; such requests never accepted by this block
//  data_sram_size    in   2       log2 bytes
//  data_sram_addr    in   ADDR_W  byte address
//  data_sram_addr_ok out  1       read accepted this cycle
//  data_sram_data_ok out  1       one-cycle pulse, rdata valid
//  data_sram_rdata   out  DATA_W  read data
//  wr_busy           in   1       write path holds an unfinished write (AW issued, B not yet seen)
//  wr_addr           in   ADDR_W  address of that write
//  arid/araddr/arsize  out  ID_W/ADDR_W/3  request fields; arsize={1'b0,size}
//  arlen/arburst/arlock/arcache/arprot  out  8/2/2/4/3  constants 0/1/0/0/0
//  arvalid/arready   out/in  1    AR handshake
//  rid/rdata/rresp/rlast/rvalid  in  ID_W/DATA_W/2/1/1  R channel
//  rready            out  1       R accept
// BEHAVIOUR
//  Reset (resetn=0, async): FSM=IDLE; arvalid=0; araddr/arid/arsize=0; rready=0.
//    Both busy flags=0; both data_ok=0; both rdata=0.
//    Outstanding reads are discarded. Reset mid-transfer needs no drain.
//  AR FSM has two states, IDLE and SEND.
//  IDLE: candidate set and priority.
//    data_cand = data_sram_req & ~data_sram_wr & ~data_busy & ~hazard.
//    hazard = wr_busy & (wr_addr[ADDR_W-1:2]==data_sram_addr[ADDR_W-1:2]).
//    inst_cand = inst_sram_req & ~inst_busy.
//    Fixed priority: data over inst.
//  IDLE: acceptance.
//    The winner's addr_ok is driven combinationally high in that cycle.
//    araddr/arsize/arid are latched, arvalid<=1, the winner's busy<=1, go to SEND.
//    The loser's addr_ok stays 0; it retries next time the FSM is in IDLE.
//  SEND: arvalid held 1 with fields stable until arready. Then arvalid<=0, go to IDLE.
//    No addr_ok in SEND. Max request rate is one accept per 2 cycles.
//  R: rready=1 whenever out of reset.
//    On rvalid with rid==INST_ID: inst_rdata<=rdata, inst_data_ok<=1 next cycle, inst_busy<=0.
//    rid==DATA_ID is handled the same way on the data side.
//    rid matching neither ID: beat consumed and dropped.
//    rresp and rlast are ignored (arlen=0, single beat).
//  data_ok is high for exactly 1 cycle, then returns to 0. rdata holds until the next R beat for that source.
//  Minimum latency: addr_ok at T0, arvalid T1, arready T1, rvalid T2, data_ok T3.
//  Simultaneous events:
//    R beat for one source in the same cycle as IDLE accepting the other source: both take effect.
//    R beat clears busy on the clock edge, so the same source may be accepted again in its data_ok cycle.
//    R beats for both sources in successive cycles: each gets its own data_ok pulse, with no loss.
//  Hazard: the data read stalls (addr_ok=0) while hazard=1. The inst read may win meanwhile.
// STRUCTURE
//  Shared package holds: ID constants (INST_ID, DATA_ID), FSM state encoding (IDLE=0, SEND=1), and the AXI constant fields.
//  Sub-module rd_pick: combinational hazard compare plus priority select.
//    Inputs: req, wr, busy, address.
//    Outputs: grant_inst, grant_data.
//  Top level keeps the FSM, AR registers, busy flags and R routing.
// TESTING
//  1. Inst read 0xBFC00000, arready=1 immediately, R rid=0 rdata=0x3C1D0001 2 cycles later
//     -> addr_ok at T0, arvalid T1 only, inst_data_ok single pulse, rdata=0x3C1D0001.
//  2. inst_sram_req and data_sram_req (read 0x80001000) in the same cycle
//     -> data_sram_addr_ok first (arid=1); inst accepted 2 cycles later (arid=0).
//  3. Both reads outstanding, R returns rid=1 then rid=0 (out of order)
//     -> data_ok then inst_data_ok, each carrying its own rdata.
//  4. wr_busy=1 with wr_addr=0x80002004; data read 0x80002006
//     -> no addr_ok until wr_busy=0, then accepted next IDLE. A read to 0x80002008 proceeds immediately.
//  5. arready held 0 for 5 cycles -> arvalid/araddr/arid stable throughout, no further addr_ok.
//  6. resetn pulsed low while in SEND with a read outstanding
//     -> arvalid=0 and busy=0 immediately; a later stray R beat rid=0 yields one data_ok pulse and no hang.

Source files
------------

// File: rtl/ar_r_read_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// ar_r_read_arbiter_pkg : source IDs, AR FSM encoding and fixed AR fields
// Revision 1.0
// =============================================================================
package ar_r_read_arbiter_pkg;

   localparam int c_INST_ID = 0;
   localparam int c_DATA_ID = 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } ar_state_t;

   // Single-beat, incrementing, normal, non-cacheable, unprivileged reads
   localparam logic [7:0] c_ARLEN   = 8'd0;
   localparam logic [1:0] c_ARBURST = 2'b01;
   localparam logic [1:0] c_ARLOCK  = 2'b00;
   localparam logic [3:0] c_ARCACHE = 4'b0000;
   localparam logic [2:0] c_ARPROT  = 3'b000;

   function automatic logic [2:0] f_arsize(input logic [1:0] size);
      return {1'b0, size};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ar_r_read_arbiter_if.sv
`default_nettype none
// =============================================================================
// ar_r_read_arbiter_if : sram-like inst/data read ports, write-hazard status, AXI AR/R
// Revision 1.0
// =============================================================================
interface ar_r_read_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);
   logic              inst_sram_req;
   logic [1:0]        inst_sram_size;
   logic [ADDR_W-1:0] inst_sram_addr;
   logic              inst_sram_addr_ok;
   logic              inst_sram_data_ok;
   logic [DATA_W-1:0] inst_sram_rdata;

   logic              data_sram_req;
   logic              data_sram_wr;
   logic [1:0]        data_sram_size;
   logic [ADDR_W-1:0] data_sram_addr;
   logic              data_sram_addr_ok;
   logic              data_sram_data_ok;
   logic [DATA_W-1:0] data_sram_rdata;

   logic              wr_busy;
   logic [ADDR_W-1:0] wr_addr;

   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [2:0]        arsize;
   logic [7:0]        arlen;
   logic [1:0]        arburst;
   logic [1:0]        arlock;
   logic [3:0]        arcache;
   logic [2:0]        arprot;
   logic              arvalid;
   logic              arready;

   logic [ID_W-1:0]   rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   // The arbiter is the AXI read master
   modport master (
      input  inst_sram_req, inst_sram_size, inst_sram_addr,
      output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
      input  wr_busy, wr_addr,
      output arid, araddr, arsize, arlen, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      output inst_sram_req, inst_sram_size, inst_sram_addr,
      input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
      output wr_busy, wr_addr,
      input  arid, araddr, arsize, arlen, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface
`default_nettype wire

// File: rtl/ar_r_read_arbiter_rd_pick.sv
`default_nettype none
// =============================================================================
// ar_r_read_arbiter_rd_pick : RAW hazard compare and data-over-inst read select
// Revision 1.0
// =============================================================================
module ar_r_read_arbiter_rd_pick
   import ar_r_read_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              i_idle,
   input  logic              i_inst_req,
   input  logic              i_inst_busy,
   input  logic              i_data_req,
   input  logic              i_data_wr,
   input  logic              i_data_busy,
   input  logic [ADDR_W-1:0] i_data_addr,
   input  logic              i_wr_busy,
   input  logic [ADDR_W-1:0] i_wr_addr,
   output logic              o_grant_inst,
   output logic              o_grant_data
);

   logic w_hazard;
   logic w_data_cand;
   logic w_inst_cand;

   // Word-granular compare: any read touching the word being written must wait
   assign w_hazard    = i_wr_busy & (i_wr_addr[ADDR_W-1:2] == i_data_addr[ADDR_W-1:2]);
   assign w_data_cand = i_data_req & ~i_data_wr & ~i_data_busy & ~w_hazard;
   assign w_inst_cand = i_inst_req & ~i_inst_busy;

   assign o_grant_data = i_idle & w_data_cand;
   assign o_grant_inst = i_idle & w_inst_cand & ~w_data_cand;

   wire w_unused = &{1'b0, i_data_addr[1:0], i_wr_addr[1:0]};

endmodule
`default_nettype wire

// File: rtl/ar_r_read_arbiter.sv
`default_nettype none
// =============================================================================
// ar_r_read_arbiter : shares AXI AR/R between inst and data reads, routes R by rid
// Revision 1.0
// =============================================================================
module ar_r_read_arbiter
   import ar_r_read_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int ID_W    = 4,
   parameter int INST_ID = c_INST_ID,
   parameter int DATA_ID = c_DATA_ID
) (
   input  wire logic            clk,
   input  wire logic            resetn,
   ar_r_read_arbiter_if.master  bus
);

   ar_state_t         r_state;
   logic              r_arvalid;
   logic [ADDR_W-1:0] r_araddr;
   logic [ID_W-1:0]   r_arid;
   logic [2:0]        r_arsize;
   logic              r_inst_busy;
   logic              r_data_busy;
   logic              r_rready;
   logic              r_inst_data_ok;
   logic              r_data_data_ok;
   logic [DATA_W-1:0] r_inst_rdata;
   logic [DATA_W-1:0] r_data_rdata;

   logic              w_grant_inst;
   logic              w_grant_data;
   logic              w_r_fire;
   logic              w_r_inst;
   logic              w_r_data;

   ar_r_read_arbiter_rd_pick #(
      .ADDR_W (ADDR_W)
   ) u_rd_pick (
      .i_idle       (r_state == ST_IDLE),
      .i_inst_req   (bus.inst_sram_req),
      .i_inst_busy  (r_inst_busy),
      .i_data_req   (bus.data_sram_req),
      .i_data_wr    (bus.data_sram_wr),
      .i_data_busy  (r_data_busy),
      .i_data_addr  (bus.data_sram_addr),
      .i_wr_busy    (bus.wr_busy),
      .i_wr_addr    (bus.wr_addr),
      .o_grant_inst (w_grant_inst),
      .o_grant_data (w_grant_data)
   );

   assign w_r_fire = bus.rvalid & r_rready;
   assign w_r_inst = w_r_fire & (bus.rid == ID_W'(INST_ID));
   assign w_r_data = w_r_fire & (bus.rid == ID_W'(DATA_ID));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_arvalid <= 1'b0;
         r_araddr  <= '0;
         r_arid    <= '0;
         r_arsize  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_data) begin
                  r_araddr  <= bus.data_sram_addr;
                  r_arsize  <= f_arsize(bus.data_sram_size);
                  r_arid    <= ID_W'(DATA_ID);
                  r_arvalid <= 1'b1;
                  r_state   <= ST_SEND;
               end else if (w_grant_inst) begin
                  r_araddr  <= bus.inst_sram_addr;
                  r_arsize  <= f_arsize(bus.inst_sram_size);
                  r_arid    <= ID_W'(INST_ID);
                  r_arvalid <= 1'b1;
                  r_state   <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (bus.arready) begin
                  r_arvalid <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               r_arvalid <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   // A new accept overrides a same-cycle return for that source (stale beat)
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_inst_busy <= 1'b0;
         r_data_busy <= 1'b0;
      end else begin
         if (w_grant_inst) begin
            r_inst_busy <= 1'b1;
         end else if (w_r_inst) begin
            r_inst_busy <= 1'b0;
         end
         if (w_grant_data) begin
            r_data_busy <= 1'b1;
         end else if (w_r_data) begin
            r_data_busy <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rready       <= 1'b0;
         r_inst_data_ok <= 1'b0;
         r_data_data_ok <= 1'b0;
         r_inst_rdata   <= '0;
         r_data_rdata   <= '0;
      end else begin
         r_rready       <= 1'b1;
         r_inst_data_ok <= w_r_inst;
         r_data_data_ok <= w_r_data;
         if (w_r_inst) begin
            r_inst_rdata <= bus.rdata;
         end
         if (w_r_data) begin
            r_data_rdata <= bus.rdata;
         end
      end
   end

   assign bus.inst_sram_addr_ok = w_grant_inst;
   assign bus.data_sram_addr_ok = w_grant_data;
   assign bus.inst_sram_data_ok = r_inst_data_ok;
   assign bus.data_sram_data_ok = r_data_data_ok;
   assign bus.inst_sram_rdata   = r_inst_rdata;
   assign bus.data_sram_rdata   = r_data_rdata;

   assign bus.arid    = r_arid;
   assign bus.araddr  = r_araddr;
   assign bus.arsize  = r_arsize;
   assign bus.arlen   = c_ARLEN;
   assign bus.arburst = c_ARBURST;
   assign bus.arlock  = c_ARLOCK;
   assign bus.arcache = c_ARCACHE;
   assign bus.arprot  = c_ARPROT;
   assign bus.arvalid = r_arvalid;
   assign bus.rready  = r_rready;

   // Single-beat reads: response status and last flag carry no information here
   wire w_unused = &{1'b0, bus.rresp, bus.rlast};

endmodule
`default_nettype wire

// File: tb/tb_ar_r_read_arbiter.sv
`default_nettype none
// =============================================================================
// tb_ar_r_read_arbiter : directed scenarios plus randomized traffic against a reference model
// Revision 1.0
// =============================================================================
module tb_ar_r_read_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   ar_r_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus_if ();

   ar_r_read_arbiter #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .ID_W   (ID_W)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus_if)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Slave memory contents: any address maps to a distinct word
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
   } rd_t;
   rd_t slv_q[$];

   // Reference model: one AR slot on the bus, one outstanding read per source
   logic        m_send, m_ibusy, m_dbusy, m_iok, m_dok, m_rready, m_e2e;
   logic [31:0] m_ar_addr, m_irdata, m_drdata, m_ireq_addr, m_dreq_addr;
   logic [3:0]  m_ar_id;
   logic [2:0]  m_ar_size;

   task automatic model_reset();
      m_send = 0; m_ibusy = 0; m_dbusy = 0; m_iok = 0; m_dok = 0; m_rready = 0;
      m_ar_addr = 0; m_ar_id = 0; m_ar_size = 0; m_irdata = 0; m_drdata = 0;
      m_ireq_addr = 0; m_dreq_addr = 0;
      slv_q.delete();
   endtask

   task automatic idle_inputs();
      bus_if.inst_sram_req = 0; bus_if.inst_sram_size = 2'd2; bus_if.inst_sram_addr = 0;
      bus_if.data_sram_req = 0; bus_if.data_sram_wr = 0; bus_if.data_sram_size = 2'd2;
      bus_if.data_sram_addr = 0; bus_if.wr_busy = 0; bus_if.wr_addr = 0;
      bus_if.arready = 0; bus_if.rvalid = 0; bus_if.rid = 0; bus_if.rdata = 0;
      bus_if.rresp = 0; bus_if.rlast = 1;
   endtask

   // Compare all outputs with the model at the negedge, then advance the model
   task automatic check_cycle();
      logic hz, g_d, g_i;
      hz  = bus_if.wr_busy && (bus_if.wr_addr[31:2] == bus_if.data_sram_addr[31:2]);
      g_d = !m_send && bus_if.data_sram_req && !bus_if.data_sram_wr && !m_dbusy && !hz;
      g_i = !m_send && bus_if.inst_sram_req && !m_ibusy && !g_d;
      chk("data_addr_ok", bus_if.data_sram_addr_ok, g_d);
      chk("inst_addr_ok", bus_if.inst_sram_addr_ok, g_i);
      chk("arvalid", bus_if.arvalid, m_send);
      if (m_send) begin
         chk("araddr", bus_if.araddr, m_ar_addr);
         chk("arid", bus_if.arid, m_ar_id);
         chk("arsize", bus_if.arsize, m_ar_size);
         chk("ar_const", {bus_if.arlen, bus_if.arburst, bus_if.arlock, bus_if.arcache, bus_if.arprot},
             {8'd0, 2'b01, 2'b00, 4'd0, 3'd0});
      end
      chk("inst_data_ok", bus_if.inst_sram_data_ok, m_iok);
      chk("inst_rdata", bus_if.inst_sram_rdata, m_irdata);
      chk("data_data_ok", bus_if.data_sram_data_ok, m_dok);
      chk("data_rdata", bus_if.data_sram_rdata, m_drdata);
      chk("rready", bus_if.rready, m_rready);
      if (m_e2e && m_iok) chk("inst_e2e", bus_if.inst_sram_rdata, mem_f(m_ireq_addr));
      if (m_e2e && m_dok) chk("data_e2e", bus_if.data_sram_rdata, mem_f(m_dreq_addr));

      if (m_send && bus_if.arready) begin
         slv_q.push_back('{id: m_ar_id, addr: m_ar_addr});
         m_send = 0;
      end
      m_iok = 0;
      m_dok = 0;
      if (bus_if.rvalid && m_rready) begin
         if (bus_if.rid == 4'd0) begin
            m_iok = 1; m_irdata = bus_if.rdata; m_ibusy = 0;
         end else if (bus_if.rid == 4'd1) begin
            m_dok = 1; m_drdata = bus_if.rdata; m_dbusy = 0;
         end
      end
      if (g_d) begin
         m_send = 1; m_ar_addr = bus_if.data_sram_addr; m_ar_id = 4'd1;
         m_ar_size = {1'b0, bus_if.data_sram_size}; m_dbusy = 1; m_dreq_addr = bus_if.data_sram_addr;
      end else if (g_i) begin
         m_send = 1; m_ar_addr = bus_if.inst_sram_addr; m_ar_id = 4'd0;
         m_ar_size = {1'b0, bus_if.inst_sram_size}; m_ibusy = 1; m_ireq_addr = bus_if.inst_sram_addr;
      end
      m_rready = 1;
   endtask

   // Called at posedge+1 with inputs set; returns at the next posedge+1
   task automatic step();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic rbeat(input logic [3:0] id, input logic [31:0] d);
      bus_if.rvalid = 1; bus_if.rid = id; bus_if.rdata = d;
      step();
      bus_if.rvalid = 0;
   endtask

   task automatic reset_pulse();
      resetn = 0;
      #1;
      chk("rst_arvalid", bus_if.arvalid, 1'b0);
      chk("rst_araddr", {bus_if.araddr, bus_if.arid, bus_if.arsize}, '0);
      chk("rst_rready", bus_if.rready, 1'b0);
      chk("rst_data_ok", {bus_if.inst_sram_data_ok, bus_if.data_sram_data_ok}, 2'b00);
      chk("rst_rdata", {bus_if.inst_sram_rdata, bus_if.data_sram_rdata}, 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      resetn = 1;
   endtask

   task automatic drive_random();
      bus_if.inst_sram_req  = ($urandom % 3) != 0;
      bus_if.inst_sram_size = 2'd2;
      bus_if.inst_sram_addr = 32'hBFC0_0000 + ($urandom % 16) * 4;
      bus_if.data_sram_req  = $urandom % 2;
      bus_if.data_sram_wr   = ($urandom % 5) == 0;
      bus_if.data_sram_size = 2'($urandom % 3);
      bus_if.data_sram_addr = 32'h8000_2000 + ($urandom % 16);
      bus_if.wr_busy        = ($urandom % 3) == 0;
      bus_if.wr_addr        = 32'h8000_2000 + ($urandom % 16);
      bus_if.arready        = $urandom % 2;
      bus_if.rresp          = 2'($urandom);
      bus_if.rlast          = $urandom % 2;
      bus_if.rvalid         = 0;
      if (m_rready && slv_q.size() > 0 && ($urandom % 2) == 1) begin
         int unsigned k;
         k = $urandom % slv_q.size();
         bus_if.rvalid = 1;
         bus_if.rid    = slv_q[k].id;
         bus_if.rdata  = mem_f(slv_q[k].addr);
         slv_q.delete(k);
      end else if (m_rready && ($urandom % 10) == 0) begin
         bus_if.rvalid = 1;
         bus_if.rid    = 4'd7;
         bus_if.rdata  = $urandom;
      end
   endtask

   initial begin
      m_e2e = 0;
      idle_inputs();
      model_reset();
      @(posedge clk);
      #1;
      reset_pulse();
      step();

      // 1: single inst read at minimum latency
      bus_if.inst_sram_req = 1; bus_if.inst_sram_addr = 32'hBFC0_0000; bus_if.arready = 1;
      step();
      bus_if.inst_sram_req = 0;
      step();
      rbeat(4'd0, 32'h3C1D_0001);
      step();
      step();
      chk("t1_rdata", bus_if.inst_sram_rdata, 32'h3C1D_0001);

      // 2: simultaneous requests, data wins first
      bus_if.arready = 0;
      bus_if.inst_sram_req = 1; bus_if.inst_sram_addr = 32'hBFC0_0010;
      bus_if.data_sram_req = 1; bus_if.data_sram_addr = 32'h8000_1000;
      step();
      bus_if.data_sram_req = 0; bus_if.arready = 1;
      chk("t2_arid_data", bus_if.arid, 4'd1);
      step();
      step();
      bus_if.inst_sram_req = 0;
      chk("t2_arid_inst", bus_if.arid, 4'd0);
      step();

      // 3: both outstanding, returned out of order
      bus_if.arready = 0;
      rbeat(4'd1, 32'hD0D0_0001);
      rbeat(4'd0, 32'h1111_0000);
      step();
      step();
      chk("t3_rdata", {bus_if.data_sram_rdata, bus_if.inst_sram_rdata}, {32'hD0D0_0001, 32'h1111_0000});

      // 4: RAW hazard stalls the data read until the write completes
      bus_if.wr_busy = 1; bus_if.wr_addr = 32'h8000_2004;
      bus_if.data_sram_req = 1; bus_if.data_sram_addr = 32'h8000_2006;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t4_stall", bus_if.data_sram_addr_ok, 1'b0);
         step();
      end
      bus_if.wr_busy = 0;
      #1;
      chk("t4_go", bus_if.data_sram_addr_ok, 1'b1);
      step();
      bus_if.data_sram_req = 0; bus_if.arready = 1;
      step();
      rbeat(4'd1, 32'h0000_4444);
      step();
      bus_if.wr_busy = 1; bus_if.data_sram_req = 1; bus_if.data_sram_addr = 32'h8000_2008;
      #1;
      chk("t4_nohazard", bus_if.data_sram_addr_ok, 1'b1);
      step();
      bus_if.data_sram_req = 0; bus_if.wr_busy = 0;
      step();
      rbeat(4'd1, 32'h0000_5555);
      step();

      // 5: AR held stable under back-pressure
      bus_if.arready = 0;
      bus_if.inst_sram_req = 1; bus_if.inst_sram_addr = 32'hBFC0_0040;
      step();
      bus_if.inst_sram_req = 0;
      bus_if.data_sram_req = 1; bus_if.data_sram_addr = 32'h8000_3000;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_hold", {bus_if.arvalid, bus_if.araddr, bus_if.arid}, {1'b1, 32'hBFC0_0040, 4'd0});
      end
      bus_if.data_sram_req = 0; bus_if.arready = 1;
      step();

      // 6: reset while a data AR is pending and an inst read is outstanding
      bus_if.data_sram_req = 1; bus_if.data_sram_addr = 32'h8000_4000; bus_if.arready = 0;
      step();
      bus_if.data_sram_req = 0;
      step();
      #2;
      reset_pulse();
      step();
      step();
      rbeat(4'd0, 32'hCAFE_0000);
      step();
      step();
      chk("t6_rdata", bus_if.inst_sram_rdata, 32'hCAFE_0000);
      bus_if.inst_sram_req = 1; bus_if.inst_sram_addr = 32'hBFC0_0080; bus_if.arready = 1;
      #1;
      chk("t6_accept", bus_if.inst_sram_addr_ok, 1'b1);
      step();
      bus_if.inst_sram_req = 0;
      step();
      rbeat(4'd0, 32'h0BAD_F00D);
      step();

      // Randomized traffic with an out-of-order slave and stray beats
      idle_inputs();
      reset_pulse();
      m_e2e = 1;
      for (int i = 0; i < 2000; i++) begin
         drive_random();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
